// File: rtl/mem8x8_pkg.sv
// Shared types and defaults for the 8x8 bitcell-array sequencer.
package mem8x8_pkg;

  localparam int ROWS_DEF    = 8;
  localparam int COLS_DEF    = 8;
  localparam int ACC_CYC_DEF = 1;

  // Verify states are always declared; the FSM only enters them when
  // MEM8X8_VERIFY_EN is defined.
  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, HOLD, RESP, VSETUP, VACCESS, VHOLD
  } state_t;

  // Width of a counter that must reach n-1 (at least 1 bit).
  function automatic int cnt_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/row_decoder.sv
// Binary row address to one-hot row select. Out-of-range addresses and
// en=0 give all-zero, so the array never sees a stray select.
module row_decoder #(
  parameter int ROWS   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [ROWS-1:0]   sel
);

  // One comparator per row; no row matches an address >= ROWS.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign sel[r] = en && (addr == ADDR_W'(r));
  end

endmodule

// File: rtl/mem8x8_ctrl.sv
// Sequencer in front of the 8x8 bitcell array.
// Each request runs SETUP -> ACCESS -> HOLD -> RESP so that rw/inp settle
// before the row select rises and stay put until after it falls; the
// cell write enable (rw & sel) is therefore glitch-free.
// Build option: MEM8X8_VERIFY_EN adds a read-back pass after every write
// and reports a data mismatch on rsp_err.
module mem8x8_ctrl
  import mem8x8_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int ADDR_W  = $clog2(ROWS),
  parameter int ACC_CYC = ACC_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [COLS-1:0]   req_data,
  output logic              rsp_valid,
  output logic [COLS-1:0]   rsp_data,
  output logic              rsp_err,
  output logic [ROWS-1:0]   mem_sel,
  output logic              mem_rw,
  output logic [COLS-1:0]   mem_inp,
  input  logic [COLS-1:0]   mem_outp
);

  localparam int              CNT_W    = cnt_w(ACC_CYC);
  localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACC_CYC - 1);

  state_t              state;
  logic                lat_rw;
  logic [ADDR_W-1:0]   lat_addr;
  logic [CNT_W-1:0]    acc_cnt;
  logic [ROWS-1:0]     dec_sel;
  logic                dec_en;
  logic                acc_last;
`ifdef MEM8X8_VERIFY_EN
  logic [COLS-1:0]     lat_data;
  logic [COLS-1:0]     vbuf;
`endif

  // Decode only on the cycle before select rises; the result is registered.
  assign dec_en = (state == SETUP) || (state == VSETUP);

  row_decoder #(
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_row_decoder (
    .en   (dec_en),
    .addr (lat_addr),
    .sel  (dec_sel)
  );

  assign req_ready = (state == IDLE) & ~rst;
  assign acc_last  = (acc_cnt == ACC_LAST);

`ifndef MEM8X8_VERIFY_EN
  assign rsp_err = 1'b0;
`endif

  // Transaction FSM; every array/response output is registered here and
  // reflects the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_rw    <= 1'b0;
      lat_addr  <= '0;
      acc_cnt   <= '0;
      mem_sel   <= '0;
      mem_rw    <= 1'b0;
      mem_inp   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
`ifdef MEM8X8_VERIFY_EN
      lat_data  <= '0;
      vbuf      <= '0;
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_rw   <= req_rw;
            lat_addr <= req_addr;
`ifdef MEM8X8_VERIFY_EN
            lat_data <= req_data;
`endif
            // rw/inp go out now, a full cycle ahead of sel.
            mem_rw   <= req_rw;
            mem_inp  <= req_rw ? req_data : '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          mem_sel <= dec_sel;
          acc_cnt <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (acc_last) begin
            mem_sel <= '0;
            // Undriven bus for an unmapped row reads back as zero.
            if (!lat_rw) rsp_data <= (|mem_sel) ? mem_outp : '0;
            state   <= HOLD;
          end else begin
            acc_cnt <= acc_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
`ifdef MEM8X8_VERIFY_EN
          if (lat_rw) begin
            // Switch to read with sel low, same ordering as a normal read.
            mem_rw  <= 1'b0;
            mem_inp <= '0;
            state   <= VSETUP;
          end else begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`else
          rsp_valid <= 1'b1;
          state     <= RESP;
`endif
        end
        RESP: begin
          rsp_valid <= 1'b0;
          mem_rw    <= 1'b0;
          mem_inp   <= '0;
`ifdef MEM8X8_VERIFY_EN
          rsp_err   <= 1'b0;
`endif
          state     <= IDLE;
        end
`ifdef MEM8X8_VERIFY_EN
        VSETUP: begin
          mem_sel <= dec_sel;
          acc_cnt <= '0;
          state   <= VACCESS;
        end
        VACCESS: begin
          if (acc_last) begin
            mem_sel <= '0;
            vbuf    <= (|mem_sel) ? mem_outp : '0;
            state   <= VHOLD;
          end else begin
            acc_cnt <= acc_cnt + CNT_W'(1);
          end
        end
        VHOLD: begin
          rsp_valid <= 1'b1;
          rsp_err   <= (vbuf != lat_data);
          state     <= RESP;
        end
`endif
        default: begin
          mem_sel <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem8x8_ctrl.sv
// Bench: controller driving a behavioural 8-row bitcell array.
module tb_mem8x8_ctrl;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int AW   = 3;
  localparam int ACC  = 1;
`ifdef MEM8X8_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_rw = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [COLS-1:0] req_data = '0;
  logic            rsp_valid;
  logic [COLS-1:0] rsp_data;
  logic            rsp_err;
  logic [ROWS-1:0] mem_sel;
  logic            mem_rw;
  logic [COLS-1:0] mem_inp;
  wire  [COLS-1:0] mem_outp;

  mem8x8_ctrl #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(AW), .ACC_CYC(ACC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_sel(mem_sel), .mem_rw(mem_rw), .mem_inp(mem_inp), .mem_outp(mem_outp)
  );

  always #5 clk = ~clk;

  // Bitcell array: stores inp while rw & sel, drives the bus when selected for read.
  logic [COLS-1:0] cells [ROWS];
  logic            cell_init = 1'b1;
  logic [COLS-1:0] flip_mask = '0;
  logic [COLS-1:0] rd_word;
  logic            rd_en;

  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (cell_init)                 cells[r] <= COLS'(8'h10 + r);
      else if (mem_sel[r] && mem_rw) cells[r] <= mem_inp;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int r = 0; r < ROWS; r++)
      if (mem_sel[r]) rd_word = cells[r];
  end
  assign rd_en    = (|mem_sel) & ~mem_rw;
  assign mem_outp = rd_en ? (rd_word ^ flip_mask) : {COLS{1'bz}};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Continuous protocol watch on the array interface.
  int              chk_bad = 0;
  logic [ROWS-1:0] p_sel = '0;
  logic            p_rw  = 1'b0;
  logic [COLS-1:0] p_inp = '0;
  logic            p_rst = 1'b1;
  always @(negedge clk) begin
    if (!rst && !p_rst) begin
      if ($countones(mem_sel) > 1) begin
        chk_bad <= chk_bad + 1;
        $display("FAIL sel_onehot: got %b", mem_sel);
      end
      if (mem_sel != 0 && p_sel != 0 && (mem_rw != p_rw || mem_inp != p_inp)) begin
        chk_bad <= chk_bad + 1;
        $display("FAIL rw_inp_stable: rw %b->%b inp %h->%h", p_rw, mem_rw, p_inp, mem_inp);
      end
      if (mem_sel != p_sel && mem_rw != p_rw) begin
        chk_bad <= chk_bad + 1;
        $display("FAIL sel_rw_same_edge: sel %b->%b rw %b->%b", p_sel, mem_sel, p_rw, mem_rw);
      end
      if (!rsp_valid && rsp_err) begin
        chk_bad <= chk_bad + 1;
        $display("FAIL rsp_err_idle: got 1 expected 0");
      end
    end
    p_sel <= mem_sel;
    p_rw  <= mem_rw;
    p_inp <= mem_inp;
    p_rst <= rst;
  end

  // One request from accept to response, with latency and select-window checks.
  task automatic txn(input string nm, input logic rw, input logic [AW-1:0] addr,
                     input logic [COLS-1:0] data, input logic [COLS-1:0] exp_data,
                     input logic exp_err, input logic [COLS-1:0] mask);
    int n, w, sel_cyc;
    logic [ROWS-1:0] sel_seen;
    bit got;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_data = data; flip_mask = mask;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) begin
      check({nm, "_ready_timeout"}, 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Junk on the request fields must be ignored while busy.
    req_valid = 1'b0; req_rw = ~rw; req_addr = ~addr; req_data = ~data;
    n = 0; got = 0; sel_cyc = 0; sel_seen = '0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (mem_sel != 0) begin sel_cyc++; sel_seen |= mem_sel; end
      if (rsp_valid) got = 1;
    end
    check({nm, "_latency"}, got ? n : 99, (rw && VER) ? 6 + ACC : 3 + ACC);
    check({nm, "_rsp_data"}, rsp_data, exp_data);
    check({nm, "_rsp_err"}, rsp_err, exp_err);
    check({nm, "_sel_row"}, sel_seen, ROWS'(1) << addr);
    check({nm, "_sel_cycles"}, sel_cyc, (rw && VER) ? 2 * ACC : ACC);
    @(negedge clk);
    check({nm, "_rsp_pulse"}, rsp_valid, 0);
    flip_mask = '0;
  endtask

  typedef struct {
    logic            rw;
    logic [AW-1:0]   addr;
    logic [COLS-1:0] data;
    logic [COLS-1:0] exp;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt [10];
    int   n, nr, na, dbl;
    int   acc_at [3];
    bit   prev_rv;

    // exp = rsp_data after the response; writes leave it at the last read.
    vt[0] = '{1'b1, 3'd3, 8'hA5, 8'h00};
    vt[1] = '{1'b0, 3'd3, 8'h00, 8'hA5};
    vt[2] = '{1'b1, 3'd0, 8'hFF, 8'hA5};
    vt[3] = '{1'b1, 3'd7, 8'h00, 8'hA5};
    vt[4] = '{1'b0, 3'd0, 8'h00, 8'hFF};
    vt[5] = '{1'b0, 3'd7, 8'h00, 8'h00};
    vt[6] = '{1'b0, 3'd1, 8'h00, 8'h11};
    vt[7] = '{1'b0, 3'd6, 8'h00, 8'h16};
    vt[8] = '{1'b1, 3'd2, 8'h5A, 8'h16};
    vt[9] = '{1'b0, 3'd2, 8'h00, 8'h5A};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_sel", mem_sel, 0);
    check("rst_mem_rw", mem_rw, 0);
    check("rst_mem_inp", mem_inp, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    rst = 1'b0; cell_init = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);

    for (int i = 0; i < 10; i++)
      txn($sformatf("vec%0d", i), vt[i].rw, vt[i].addr, vt[i].data, vt[i].exp, 1'b0, '0);

    // Reset during the ACCESS cycle of a write: sel drops at once, write lost.
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 3'd5; req_data = 8'h3C;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    while (mem_sel == 0 && n < 10) begin @(negedge clk); n++; end
    check("midrst_in_access", mem_sel, 8'h20);
    rst = 1'b1; #1;
    check("midrst_sel_drop", mem_sel, 0);
    check("midrst_ready_low", req_ready, 0);
    @(negedge clk); rst = 1'b0;
    nr = 0;
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (rsp_valid) nr++; end
    check("midrst_no_rsp", nr, 0);
    check("midrst_ready", req_ready, 1);
    txn("midrst_row5_kept", 1'b0, 3'd5, 8'h00, 8'h15, 1'b0, '0);

    // Back-to-back reads with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 3'd3; req_data = '0;
    na = 0; nr = 0; dbl = 0; prev_rv = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (na == 3) req_valid = 1'b0;
      if (req_valid && req_ready && na < 3) begin acc_at[na] = k; na++; end
      if (rsp_valid) begin
        nr++;
        check("b2b_rsp_data", rsp_data, 8'hA5);
        if (prev_rv) dbl++;
      end
      prev_rv = rsp_valid;
    end
    req_valid = 1'b0;
    check("b2b_accepts", na, 3);
    check("b2b_space1", acc_at[1] - acc_at[0], 5);
    check("b2b_space2", acc_at[2] - acc_at[1], 5);
    check("b2b_rsp_count", nr, 3);
    check("b2b_rsp_single", dbl, 0);

    // Corrupted read-back flags rsp_err (verify build); clean write clears it.
    txn("vfy_bad", 1'b1, 3'd4, 8'hC3, 8'hA5, VER, 8'h04);
    txn("vfy_good", 1'b1, 3'd4, 8'h77, 8'hA5, 1'b0, '0);
    txn("vfy_read", 1'b0, 3'd4, 8'h00, 8'h77, 1'b0, '0);

    repeat (2) @(negedge clk);
    check("protocol", chk_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
